sort_datapath: RTL and testbench
================================

Name: sort_datapath

Overview:
- Datapath and register bank that answers the insertion-sort controller's select lines. Decodes sSelDecoA/B as read-operand selects, sSelDecoC as the write-back select and sSelAlu as the ALU opcode.
- Returns the status flags (sOverflow, sCarry, sNegative, sZero, sPar) to the controller in the same cycle.
- Also owns the front and back ends of a sort:
  - a valid/ready loader that fills RP0..RP4 and pulses sStart;
  - an unloader that streams sorted R0..R4 out once the controller reports done.

Parameters:
- DATAWIDTH, 8, operand/register width.
- SELECTIONALU, 3, ALU select width.
- SELECTIONDECO, 4, decoder select width.

Ports:
- clk  in  1  rising-edge clock.
- highRst  in  1  asynchronous active-high reset.
- sSelDecoA  in  SELECTIONDECO  operand A select.
- sSelDecoB  in  SELECTIONDECO  operand B select.
- sSelDecoC  in  SELECTIONDECO  write-back select.
- sSelAlu  in  SELECTIONALU  ALU opcode.
- sSortDone  in  1  controller reports sort complete.
- sInValid  in  1  input word valid.
- sInReady  out  1  loader can accept.
- sInData  in  DATAWIDTH  unsorted input word.
- sStart  out  1  one-cycle start pulse to controller.
- sOverflow, sCarry, sNegative, sZero, sPar  out  1 each  ALU flags, combinational.
- sOutValid  out  1  sorted word valid.
- sOutReady  in  1  sink accepts.
- sOutData  out  DATAWIDTH  sorted word, R0 first.
- sBusy  out  1  high from first accepted input word until last output word accepted.

Behaviour:
- Reset: asynchronous active-high. R0..R4 and RP0..RP4 = 0; sequencer = LOAD with count 0. Outputs: sInReady=1, sStart=0, sOutValid=0, sOutData=0, sBusy=0.
- Read select (A and B), any other code reads 0:
  - 0000..0100 = R0..R4;
  - 0110..1010 = RP0..RP4.
- Write select C:
  - 0000..0100 writes R0..R4 with the ALU result on the next rising edge;
  - 1000 and every other code means no write.
- RP0..RP4 are writable only by the loader.
- ALU, combinational, DATAWIDTH result with wrap-around:
  - 000 pass A; 001 A-B; 010 A+B; 011 A&B; 100 A|B; 101 pass B; 110 A^B; 111 zero.
- Flags, combinational on the current cycle:
  - sZero = result==0.
  - sPar = XOR reduction of result (1 = odd count of ones).
  - sNegative = result MSB.
  - sCarry = carry out for add and borrow-free (A>=B unsigned) for sub; 0 otherwise.
  - sOverflow = signed two's-complement overflow for add/sub; 0 otherwise.
- Sequencer states:
  - LOAD: sInReady=1. Each sInValid&sInReady writes RP[count] and count++. The 5th accept goes to START with count=0.
  - START: sInReady=0, sStart=1 for exactly one cycle, then WAIT.
  - WAIT: sInReady=0; waits for sSortDone=1, then UNLOAD.
  - UNLOAD: sOutValid=1, sOutData=R[count]. On sOutValid&sOutReady, count++. After R4 is accepted, go to LOAD with count=0 and sOutValid=0.
- sOutData and sOutValid hold stable while sOutReady=0.
- sSortDone is ignored in LOAD and START. A level already high on re-entry does not re-trigger UNLOAD.
- The controller must be reset between sorts; this block does not drive its reset.
- Controller writes to R0..R4 during UNLOAD are still performed and are visible on sOutData (not guarded).
- Reset mid-operation aborts to LOAD; partially loaded data is discarded.

Optional Feature:
- SORT_DP_CMP_WIDE_EN.
- Defined: for opcode 001, sNegative = true signed A<B, computed at DATAWIDTH+1 bits, so it is immune to overflow. sOverflow and sCarry are unchanged.
- Undefined: sNegative = MSB of the DATAWIDTH result. Sorting is then correct only when the operand difference does not overflow.

Decomposition:
- Package sort_pkg:
  - ALU opcode constants (ALU_PASSA=000, ALU_SUB=001, ALU_PASSB=101, ...);
  - read-select constants (SEL_R0..SEL_R4, SEL_RP0..SEL_RP4) and SEL_NOWRITE=1000;
  - sequencer state enum (LOAD, START, WAIT, UNLOAD);
  - NUM_ELEMS=5.
- One natural sub-module: sort_alu (combinational ALU plus flags, including the SORT_DP_CMP_WIDE_EN path). The register bank and sequencer stay in the top.

Test Plan:
- Load via valid/ready: 9, 3, 7, 1, 5 -> RP0..RP4 = 9,3,7,1,5; sStart high exactly one cycle, on the cycle after the 5th accept; sInReady=0 after it.
- Load backpressure: sInValid toggling every other cycle -> exactly 5 words stored, order preserved, no duplicate or skipped write.
- Select decode: sSelDecoA=0110, sSelDecoB=0111, sSelAlu=001 with RP0=9, RP1=3 -> result 6, sNegative=0, sCarry=1, sZero=0, sPar=0. sSelDecoC=1000 -> no register changes.
- Write-back: sSelDecoB=1001 (RP3=1), sSelAlu=101, sSelDecoC=0010 -> R2=1 after one edge; R0, R1, R3, R4 unchanged.
- Overflow (DATAWIDTH=8): A=0x80, B=0x01, sub -> result 0x7F, sOverflow=1. sNegative=0 without the macro, 1 with SORT_DP_CMP_WIDE_EN.
- Unload: R0..R4 = 1,3,5,7,9, then sSortDone=1 -> stream 1,3,5,7,9. With sOutReady stalled 3 cycles on word 2, sOutData holds 5 throughout. Return to LOAD with sBusy=0. highRst asserted mid-UNLOAD -> immediately sOutValid=0 and sInReady=1.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg: shared opcodes, select codes, sequencer states and element count for the sort datapath
package sort_pkg;
  localparam int NUM_ELEMS = 5;
  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_ZERO  = 3'b111;
  localparam logic [3:0] SEL_R0 = 4'b0000;
  localparam logic [3:0] SEL_R1 = 4'b0001;
  localparam logic [3:0] SEL_R2 = 4'b0010;
  localparam logic [3:0] SEL_R3 = 4'b0011;
  localparam logic [3:0] SEL_R4 = 4'b0100;
  localparam logic [3:0] SEL_RP0 = 4'b0110;
  localparam logic [3:0] SEL_RP1 = 4'b0111;
  localparam logic [3:0] SEL_RP2 = 4'b1000;
  localparam logic [3:0] SEL_RP3 = 4'b1001;
  localparam logic [3:0] SEL_RP4 = 4'b1010;
  localparam logic [3:0] SEL_NOWRITE = 4'b1000;
  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} seq_t;
endpackage

// File: rtl/sort_alu.sv
// sort_alu: combinational ALU with flags; SORT_DP_CMP_WIDE_EN makes the subtract sign an overflow-immune signed A<B
module sort_alu
  import sort_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int SELECTIONALU = 3
) (
  input  logic [DATAWIDTH-1:0]    a,
  input  logic [DATAWIDTH-1:0]    b,
  input  logic [SELECTIONALU-1:0] op,
  output logic [DATAWIDTH-1:0]    res,
  output logic                    ovf,
  output logic                    carry,
  output logic                    neg,
  output logic                    zero,
  output logic                    par
);
  localparam int W = DATAWIDTH;
  logic [W:0] sum, diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    res = '0;
    case (op)
      ALU_PASSA: res = a;
      ALU_SUB:   res = diff[W-1:0];
      ALU_ADD:   res = sum[W-1:0];
      ALU_AND:   res = a & b;
      ALU_OR:    res = a | b;
      ALU_PASSB: res = b;
      ALU_XOR:   res = a ^ b;
      default:   res = '0;
    endcase
  end
  assign carry = (op == ALU_ADD) ? sum[W] : (op == ALU_SUB) ? ~diff[W] : 1'b0;
  assign ovf = (op == ALU_ADD) ? (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]) :
               (op == ALU_SUB) ? (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]) : 1'b0;
  assign zero = (res == '0);
  assign par  = ^res;
`ifdef SORT_DP_CMP_WIDE_EN
  logic [W:0] sdiff;
  assign sdiff = {a[W-1], a} - {b[W-1], b};
  assign neg = (op == ALU_SUB) ? sdiff[W] : res[W-1];
`else
  assign neg = res[W-1];
`endif
endmodule

// File: rtl/sort_datapath.sv
// sort_datapath: register bank, operand/write-back decode and load/unload sequencer for the insertion sorter
module sort_datapath
  import sort_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int SELECTIONALU = 3,
  parameter int SELECTIONDECO = 4
) (
  input  logic                     clk,
  input  logic                     highRst,
  input  logic [SELECTIONDECO-1:0] sSelDecoA,
  input  logic [SELECTIONDECO-1:0] sSelDecoB,
  input  logic [SELECTIONDECO-1:0] sSelDecoC,
  input  logic [SELECTIONALU-1:0]  sSelAlu,
  input  logic                     sSortDone,
  input  logic                     sInValid,
  output logic                     sInReady,
  input  logic [DATAWIDTH-1:0]     sInData,
  output logic                     sStart,
  output logic                     sOverflow,
  output logic                     sCarry,
  output logic                     sNegative,
  output logic                     sZero,
  output logic                     sPar,
  output logic                     sOutValid,
  input  logic                     sOutReady,
  output logic [DATAWIDTH-1:0]     sOutData,
  output logic                     sBusy
);
  seq_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic armed_q, armed_d;
  logic [DATAWIDTH-1:0] r_q [NUM_ELEMS];
  logic [DATAWIDTH-1:0] r_d [NUM_ELEMS];
  logic [DATAWIDTH-1:0] rp_q [NUM_ELEMS];
  logic [DATAWIDTH-1:0] rp_d [NUM_ELEMS];
  logic [DATAWIDTH-1:0] op_a, op_b, alu_res;
  logic last;
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (sSelDecoA == SELECTIONDECO'(SEL_R0 + 4'(i))) op_a = r_q[i];
      if (sSelDecoA == SELECTIONDECO'(SEL_RP0 + 4'(i))) op_a = rp_q[i];
      if (sSelDecoB == SELECTIONDECO'(SEL_R0 + 4'(i))) op_b = r_q[i];
      if (sSelDecoB == SELECTIONDECO'(SEL_RP0 + 4'(i))) op_b = rp_q[i];
    end
  end
  sort_alu #(.DATAWIDTH(DATAWIDTH), .SELECTIONALU(SELECTIONALU)) u_alu (
    .a(op_a), .b(op_b), .op(sSelAlu), .res(alu_res),
    .ovf(sOverflow), .carry(sCarry), .neg(sNegative), .zero(sZero), .par(sPar)
  );
  assign last = (cnt_q == 3'(NUM_ELEMS - 1));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    armed_d = (state_q == UNLOAD) ? 1'b0 : armed_q | ~sSortDone;
    r_d = r_q;
    rp_d = rp_q;
    for (int i = 0; i < NUM_ELEMS; i++)
      if (sSelDecoC == SELECTIONDECO'(SEL_R0 + 4'(i))) r_d[i] = alu_res;
    case (state_q)
      LOAD: if (sInValid) begin
        rp_d[cnt_q] = sInData;
        cnt_d = last ? 3'd0 : cnt_q + 3'd1;
        state_d = last ? START : LOAD;
      end
      START: state_d = WAIT;
      WAIT: state_d = (sSortDone && armed_q) ? UNLOAD : WAIT;
      UNLOAD: if (sOutReady) begin
        cnt_d = last ? 3'd0 : cnt_q + 3'd1;
        state_d = last ? LOAD : UNLOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge highRst) begin
    if (highRst) begin
      state_q <= LOAD;
      cnt_q <= '0;
      armed_q <= 1'b0;
      r_q <= '{default: '0};
      rp_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      armed_q <= armed_d;
      r_q <= r_d;
      rp_q <= rp_d;
    end
  end
  assign sInReady = (state_q == LOAD);
  assign sStart = (state_q == START);
  assign sOutValid = (state_q == UNLOAD);
  assign sOutData = sOutValid ? r_q[cnt_q] : '0;
  assign sBusy = (state_q != LOAD) || (cnt_q != 3'd0);
endmodule

// File: tb/tb_sort_datapath.sv
// tb_sort_datapath: directed self-checking bench acting as the sort controller, source and sink
module tb_sort_datapath;
  import sort_pkg::*;
  logic clk = 1'b0;
  logic highRst;
  logic [3:0] sSelDecoA, sSelDecoB, sSelDecoC;
  logic [2:0] sSelAlu;
  logic sSortDone, sInValid, sInReady, sStart;
  logic [7:0] sInData, sOutData;
  logic sOverflow, sCarry, sNegative, sZero, sPar;
  logic sOutValid, sOutReady, sBusy;
  int passed = 0;
  int total = 0;
`ifdef SORT_DP_CMP_WIDE_EN
  localparam logic OVF_NEG = 1'b1;
`else
  localparam logic OVF_NEG = 1'b0;
`endif
  always #5 clk = ~clk;
  sort_datapath dut (
    .clk(clk), .highRst(highRst), .sSelDecoA(sSelDecoA), .sSelDecoB(sSelDecoB),
    .sSelDecoC(sSelDecoC), .sSelAlu(sSelAlu), .sSortDone(sSortDone), .sInValid(sInValid),
    .sInReady(sInReady), .sInData(sInData), .sStart(sStart), .sOverflow(sOverflow),
    .sCarry(sCarry), .sNegative(sNegative), .sZero(sZero), .sPar(sPar),
    .sOutValid(sOutValid), .sOutReady(sOutReady), .sOutData(sOutData), .sBusy(sBusy)
  );
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic [3:0] c);
    sSelDecoA = a;
    sSelDecoB = b;
    sSelAlu = op;
    sSelDecoC = c;
    tick;
    sSelDecoC = SEL_NOWRITE;
  endtask
  task automatic test_reset;
    total++; if (sInReady !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", sInReady); else passed++;
    total++; if (sStart !== 1'b0) $display("FAIL rst_start got %b exp 0", sStart); else passed++;
    total++; if (sOutValid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", sOutValid); else passed++;
    total++; if (sOutData !== 8'h00) $display("FAIL rst_out_data got %h exp 00", sOutData); else passed++;
    total++; if (sBusy !== 1'b0) $display("FAIL rst_busy got %b exp 0", sBusy); else passed++;
    total++; if (sZero !== 1'b1) $display("FAIL rst_zero got %b exp 1", sZero); else passed++;
    total++; if (sCarry !== 1'b0) $display("FAIL rst_carry got %b exp 0", sCarry); else passed++;
  endtask
  task automatic test_load;
    logic [7:0] v [5] = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    for (int i = 0; i < 5; i++) begin
      sInValid = 1'b1;
      sInData = v[i];
      tick;
      if (i == 0) begin
        total++; if (sBusy !== 1'b1) $display("FAIL load_busy got %b exp 1", sBusy); else passed++;
      end
      if (i < 4) begin
        total++; if (sStart !== 1'b0) $display("FAIL load_early_start[%0d] got %b exp 0", i, sStart); else passed++;
        total++; if (sInReady !== 1'b1) $display("FAIL load_ready[%0d] got %b exp 1", i, sInReady); else passed++;
      end
    end
    sInValid = 1'b0;
    total++; if (sStart !== 1'b1) $display("FAIL load_start_pulse got %b exp 1", sStart); else passed++;
    total++; if (sInReady !== 1'b0) $display("FAIL load_ready_after got %b exp 0", sInReady); else passed++;
    tick;
    total++; if (sStart !== 1'b0) $display("FAIL load_start_one_cycle got %b exp 0", sStart); else passed++;
    total++; if (sInReady !== 1'b0) $display("FAIL wait_ready got %b exp 0", sInReady); else passed++;
    total++; if (sOutValid !== 1'b0) $display("FAIL wait_out_valid got %b exp 0", sOutValid); else passed++;
  endtask
  task automatic test_select;
    for (int i = 0; i < 5; i++) wr(4'(6 + i), 4'd0, ALU_PASSA, 4'(i));
    sSelDecoA = SEL_R0; sSelDecoB = SEL_R1;
    sSelAlu = ALU_AND; #1;
    total++; if ({sZero, sPar} !== 2'b01) $display("FAIL alu_and zp got %b exp 01", {sZero, sPar}); else passed++;
    sSelAlu = ALU_OR; #1;
    total++; if ({sZero, sPar, sNegative} !== 3'b010) $display("FAIL alu_or znp got %b exp 010", {sZero, sPar, sNegative}); else passed++;
    sSelAlu = ALU_XOR; #1;
    total++; if ({sZero, sPar} !== 2'b00) $display("FAIL alu_xor zp got %b exp 00", {sZero, sPar}); else passed++;
    sSelAlu = ALU_ADD; #1;
    total++; if ({sZero, sPar, sCarry, sOverflow} !== 4'b0000) $display("FAIL alu_add zpco got %b exp 0000", {sZero, sPar, sCarry, sOverflow}); else passed++;
    sSelAlu = ALU_ZERO; #1;
    total++; if (sZero !== 1'b1) $display("FAIL alu_zero got %b exp 1", sZero); else passed++;
    sSelAlu = ALU_PASSB; sSelDecoB = 4'b0101; #1;
    total++; if (sZero !== 1'b1) $display("FAIL sel_0101_reads0 got %b exp 1", sZero); else passed++;
    sSelAlu = ALU_PASSA; sSelDecoA = 4'b1011; #1;
    total++; if (sZero !== 1'b1) $display("FAIL sel_1011_reads0 got %b exp 1", sZero); else passed++;
    sSelAlu = ALU_SUB; sSelDecoA = SEL_R1; sSelDecoB = SEL_R0; #1;
    total++; if ({sNegative, sCarry, sOverflow} !== 3'b100) $display("FAIL sub_3_9 nco got %b exp 100", {sNegative, sCarry, sOverflow}); else passed++;
    sSelDecoA = SEL_RP0; sSelDecoB = SEL_RP1; sSelDecoC = SEL_NOWRITE; #1;
    total++; if ({sZero, sNegative, sCarry, sPar, sOverflow} !== 5'b00100) $display("FAIL sub_9_3 zncpo got %b exp 00100", {sZero, sNegative, sCarry, sPar, sOverflow}); else passed++;
    tick;
  endtask
  task automatic test_writeback;
    logic [7:0] e [5] = '{8'd9, 8'd3, 8'd1, 8'd1, 8'd5};
    wr(SEL_R0, SEL_RP3, ALU_PASSB, SEL_R2);
    sSortDone = 1'b1;
    tick;
    sOutReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (sOutValid !== 1'b1 || sOutData !== e[i]) $display("FAIL wb_stream[%0d] got %b/%0d exp 1/%0d", i, sOutValid, sOutData, e[i]); else passed++;
      tick;
    end
    sOutReady = 1'b0;
    sSortDone = 1'b0;
    total++; if ({sOutValid, sInReady, sBusy} !== 3'b010) $display("FAIL wb_end vrb got %b exp 010", {sOutValid, sInReady, sBusy}); else passed++;
  endtask
  task automatic test_backpressure;
    logic [7:0] v [5] = '{8'h80, 8'h01, 8'd3, 8'd5, 8'd7};
    for (int i = 0; i < 5; i++) begin
      sInValid = 1'b0;
      sInData = 8'hEE;
      tick;
      total++; if (sInReady !== 1'b1) $display("FAIL bp_ready[%0d] got %b exp 1", i, sInReady); else passed++;
      sInValid = 1'b1;
      sInData = v[i];
      tick;
    end
    sInValid = 1'b0;
    total++; if (sStart !== 1'b1) $display("FAIL bp_start got %b exp 1", sStart); else passed++;
    tick;
  endtask
  task automatic test_overflow;
    sSelDecoA = SEL_RP0; sSelDecoB = SEL_RP1; sSelAlu = ALU_SUB; #1;
    total++; if ({sOverflow, sCarry, sZero, sPar} !== 4'b1101) $display("FAIL ovf_sub oczp got %b exp 1101", {sOverflow, sCarry, sZero, sPar}); else passed++;
    total++; if (sNegative !== OVF_NEG) $display("FAIL ovf_sub_neg got %b exp %b", sNegative, OVF_NEG); else passed++;
    sSelDecoB = SEL_RP0; sSelAlu = ALU_ADD; #1;
    total++; if ({sOverflow, sCarry, sZero} !== 3'b111) $display("FAIL ovf_add ocz got %b exp 111", {sOverflow, sCarry, sZero}); else passed++;
    wr(SEL_RP1, SEL_R0, ALU_PASSA, SEL_R0);
    wr(SEL_RP2, SEL_R0, ALU_PASSA, SEL_R1);
    wr(SEL_RP3, SEL_R0, ALU_PASSA, SEL_R2);
    wr(SEL_RP4, SEL_R0, ALU_PASSA, SEL_R3);
    wr(SEL_RP2, SEL_RP3, ALU_ADD, SEL_R4);
    wr(SEL_R4, SEL_RP1, ALU_ADD, SEL_R4);
  endtask
  task automatic test_unload_stall;
    logic [7:0] e [5] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
    sSortDone = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        sOutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick;
          total++; if (sOutValid !== 1'b1 || sOutData !== 8'd5) $display("FAIL stall_hold[%0d] got %b/%0d exp 1/5", k, sOutValid, sOutData); else passed++;
        end
      end
      sOutReady = 1'b1;
      total++; if (sOutValid !== 1'b1 || sOutData !== e[i]) $display("FAIL unload[%0d] got %b/%0d exp 1/%0d", i, sOutValid, sOutData, e[i]); else passed++;
      total++; if (sBusy !== 1'b1) $display("FAIL unload_busy[%0d] got %b exp 1", i, sBusy); else passed++;
      tick;
    end
    sOutReady = 1'b0;
    total++; if ({sOutValid, sInReady, sBusy} !== 3'b010) $display("FAIL unload_end vrb got %b exp 010", {sOutValid, sInReady, sBusy}); else passed++;
  endtask
  task automatic test_retrigger;
    for (int i = 0; i < 5; i++) begin
      sInValid = 1'b1;
      sInData = 8'(2 * i + 2);
      tick;
    end
    sInValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (sOutValid !== 1'b0) $display("FAIL stale_done[%0d] got %b exp 0", k, sOutValid); else passed++;
    end
    sSortDone = 1'b0;
    tick;
    sSortDone = 1'b1;
    tick;
    total++; if (sOutValid !== 1'b1 || sOutData !== 8'd1) $display("FAIL rearm got %b/%0d exp 1/1", sOutValid, sOutData); else passed++;
    sOutReady = 1'b1;
    tick;
    total++; if (sOutData !== 8'd3) $display("FAIL rearm_word1 got %0d exp 3", sOutData); else passed++;
  endtask
  task automatic test_reset_mid;
    highRst = 1'b1;
    #1;
    total++; if ({sOutValid, sInReady, sBusy} !== 3'b010) $display("FAIL midrst vrb got %b exp 010", {sOutValid, sInReady, sBusy}); else passed++;
    total++; if (sOutData !== 8'h00) $display("FAIL midrst_data got %h exp 00", sOutData); else passed++;
    sSelDecoA = SEL_R4; sSelAlu = ALU_PASSA; #1;
    total++; if (sZero !== 1'b1) $display("FAIL midrst_r4_cleared got %b exp 1", sZero); else passed++;
    sSortDone = 1'b0;
    sOutReady = 1'b0;
    tick;
    highRst = 1'b0;
    tick;
    total++; if ({sInReady, sOutValid} !== 2'b10) $display("FAIL post_rst ready/valid got %b exp 10", {sInReady, sOutValid}); else passed++;
  endtask
  initial begin
    highRst = 1'b0;
    sSelDecoA = SEL_R0; sSelDecoB = SEL_R0; sSelDecoC = SEL_NOWRITE; sSelAlu = ALU_ADD;
    sSortDone = 1'b0; sInValid = 1'b0; sInData = 8'h00; sOutReady = 1'b0;
    #1 highRst = 1'b1;
    #2;
    test_reset;
    #10 highRst = 1'b0;
    tick;
    test_load;
    test_select;
    test_writeback;
    test_backpressure;
    test_overflow;
    test_unload_stall;
    test_retrigger;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
